// File: rtl/id_dispatch_if.sv
// Dispatch packet bus from id_dispatch to the reservation stations.
// master drives the registered packet; slave is the station side.
interface id_dispatch_if #(
  parameter int NUM_ALU_RS = 2,
  parameter int ROB_ADDR_W = 5
);
  logic                  disp_valid_o;
  logic [NUM_ALU_RS:0]   disp_sel_o;
  logic [6:0]            disp_op_o;
  logic [2:0]            disp_funct3_o;
  logic [6:0]            disp_funct7_o;
  logic [31:0]           disp_imm_o;
  logic [4:0]            disp_rs1_o;
  logic [4:0]            disp_rs2_o;
  logic [ROB_ADDR_W-1:0] disp_rob_id_o;
  logic [31:0]           disp_pc_o;

  modport master (
    output disp_valid_o, disp_sel_o, disp_op_o,
    output disp_funct3_o, disp_funct7_o, disp_imm_o,
    output disp_rs1_o, disp_rs2_o, disp_rob_id_o,
    output disp_pc_o
  );

  modport slave (
    input disp_valid_o, disp_sel_o, disp_op_o,
    input disp_funct3_o, disp_funct7_o, disp_imm_o,
    input disp_rs1_o, disp_rs2_o, disp_rob_id_o,
    input disp_pc_o
  );
endinterface

// File: rtl/id_dispatch.sv
// RV32I decode/dispatch stage: ROB alloc, rename, round-robin
// issue to ALU stations or load/store. Inputs: clk, rst (sync,
// active-high), rdy, flush_i, queue (inst_valid_i/inst_i/pc_i),
// ROB status, station busy flags. Outputs: inst_pop_o, ROB/regfile
// requests, registered packet on disp (id_dispatch_if.master).
// Option: ID_ILLEGAL_TRAP_EN allocates unknown opcodes in the ROB.
module id_dispatch #(
  parameter int NUM_ALU_RS = 2,
  parameter int ROB_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush_i,
  input  logic                  inst_valid_i,
  input  logic [31:0]           inst_i,
  input  logic [31:0]           pc_i,
  output logic                  inst_pop_o,
  input  logic                  rob_full_i,
  input  logic [ROB_ADDR_W-1:0] rob_id_i,
  output logic                  rob_alloc_o,
  output logic [4:0]            rob_regaddr_o,
  output logic [1:0]            rob_tag_o,
  output logic                  rf_wait_en_o,
  output logic [4:0]            rf_wait_addr_o,
  output logic [ROB_ADDR_W-1:0] rf_wait_id_o,
  input  logic [NUM_ALU_RS-1:0] rs_busy_i,
  input  logic                  sl_busy_i,
  id_dispatch_if.master         disp
);

  localparam int RRW = (NUM_ALU_RS > 1) ? $clog2(NUM_ALU_RS) : 1;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  logic [6:0] op;
  logic [4:0] rd;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic is_load, is_store, is_opi, is_op;
  logic is_alu, is_sl, is_ill, has_rd;

  assign op       = inst_i[6:0];
  assign rd       = inst_i[11:7];
  assign is_lui   = (op == OP_LUI);
  assign is_auipc = (op == OP_AUIPC);
  assign is_jal   = (op == OP_JAL);
  assign is_jalr  = (op == OP_JALR);
  assign is_br    = (op == OP_BR);
  assign is_load  = (op == OP_LOAD);
  assign is_store = (op == OP_STORE);
  assign is_opi   = (op == OP_IMM);
  assign is_op    = (op == OP_OP);
  assign is_alu   = is_lui | is_auipc | is_jal | is_jalr
                  | is_opi | is_op | is_br;
  assign is_sl    = is_load | is_store;
  assign is_ill   = ~(is_alu | is_sl);
  assign has_rd   = ~(is_br | is_store | is_ill);

  logic                  disp_valid_q;
  logic [NUM_ALU_RS:0]   disp_sel_q, disp_sel_d;
  logic [6:0]            op_q;
  logic [2:0]            f3_q;
  logic [6:0]            f7_q;
  logic [31:0]           imm_q, imm_d;
  logic [4:0]            rs1_q, rs1_d, rs2_q, rs2_d;
  logic [ROB_ADDR_W-1:0] robid_q;
  logic [31:0]           pc_q;
  logic [NUM_ALU_RS-1:0] pend_q, pend_d;
  logic                  pend_sl_q, pend_sl_d;
  logic [RRW-1:0]        rr_q, rr_d;

  // pend masks the station fed last cycle, whose busy flag lags.
  logic [NUM_ALU_RS-1:0] alu_free, alu_oh;
  logic [RRW-1:0]        chosen;
  logic                  found, sl_free;

  assign alu_free = ~rs_busy_i & ~pend_q;
  assign sl_free  = ~sl_busy_i & ~pend_sl_q;

  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    chosen = '0;
    for (int i = 0; i < NUM_ALU_RS; i++) begin
      idx = (int'(rr_q) + i) % NUM_ALU_RS;
      if (!found && alu_free[idx]) begin
        found  = 1'b1;
        chosen = RRW'(idx);
      end
    end
    alu_oh = found ? (NUM_ALU_RS'(1) << chosen) : '0;
  end

  logic base_ok, acc_alu, acc_sl, acc_ill, acc_disp;

  assign base_ok  = ~rst & rdy & ~flush_i & inst_valid_i;
  assign acc_alu  = base_ok & is_alu & ~rob_full_i & found;
  assign acc_sl   = base_ok & is_sl & ~rob_full_i & sl_free;
  assign acc_disp = acc_alu | acc_sl;

`ifdef ID_ILLEGAL_TRAP_EN
  assign acc_ill     = base_ok & is_ill & ~rob_full_i;
  assign rob_alloc_o = acc_disp | acc_ill;
`else
  // Unknown opcodes are silently dropped so the queue keeps moving.
  assign acc_ill     = base_ok & is_ill;
  assign rob_alloc_o = acc_disp;
`endif

  assign inst_pop_o    = acc_disp | acc_ill;
  assign rob_regaddr_o = (rob_alloc_o && has_rd) ? rd : 5'd0;
  assign rob_tag_o     = !rob_alloc_o ? 2'b00 :
                         is_ill       ? 2'b11 :
                         is_store     ? 2'b01 :
                         (is_br | is_jal | is_jalr) ? 2'b10 : 2'b00;
  assign rf_wait_en_o   = acc_disp & has_rd & (rd != 5'd0);
  assign rf_wait_addr_o = rf_wait_en_o ? rd : 5'd0;
  assign rf_wait_id_o   = rf_wait_en_o ? rob_id_i : '0;

  always_comb begin
    imm_d = 32'd0;
    unique case (1'b1)
      is_load | is_jalr | is_opi:
        imm_d = {{20{inst_i[31]}}, inst_i[31:20]};
      is_store:
        imm_d = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      is_br:
        imm_d = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                 inst_i[30:25], inst_i[11:8], 1'b0};
      is_lui | is_auipc:
        imm_d = {inst_i[31:12], 12'd0};
      is_jal:
        imm_d = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                 inst_i[20], inst_i[30:21], 1'b0};
      default:
        imm_d = 32'd0;
    endcase
  end

  assign rs1_d = (is_lui | is_auipc | is_jal) ? 5'd0 : inst_i[19:15];
  assign rs2_d = (is_op | is_br | is_store) ? inst_i[24:20] : 5'd0;

  // Flush needs no special path: it blocks accept, so pend clears
  // and rr holds naturally.
  always_comb begin
    int nx;
    nx         = (int'(chosen) + 1) % NUM_ALU_RS;
    pend_d     = acc_alu ? alu_oh : '0;
    pend_sl_d  = acc_sl;
    rr_d       = acc_alu ? RRW'(nx) : rr_q;
    disp_sel_d = acc_alu ? {1'b0, alu_oh} :
                 acc_sl  ? {1'b1, {NUM_ALU_RS{1'b0}}} : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_valid_q <= 1'b0;
      disp_sel_q   <= '0;
      op_q         <= '0;
      f3_q         <= '0;
      f7_q         <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      robid_q      <= '0;
      pc_q         <= '0;
      pend_q       <= '0;
      pend_sl_q    <= 1'b0;
      rr_q         <= '0;
    end else if (rdy) begin
      disp_valid_q <= acc_disp;
      disp_sel_q   <= disp_sel_d;
      pend_q       <= pend_d;
      pend_sl_q    <= pend_sl_d;
      rr_q         <= rr_d;
      if (acc_disp) begin
        op_q    <= op;
        f3_q    <= inst_i[14:12];
        f7_q    <= inst_i[31:25];
        imm_q   <= imm_d;
        rs1_q   <= rs1_d;
        rs2_q   <= rs2_d;
        robid_q <= rob_id_i;
        pc_q    <= pc_i;
      end
    end
  end

  assign disp.disp_valid_o  = disp_valid_q;
  assign disp.disp_sel_o    = disp_sel_q;
  assign disp.disp_op_o     = op_q;
  assign disp.disp_funct3_o = f3_q;
  assign disp.disp_funct7_o = f7_q;
  assign disp.disp_imm_o    = imm_q;
  assign disp.disp_rs1_o    = rs1_q;
  assign disp.disp_rs2_o    = rs2_q;
  assign disp.disp_rob_id_o = robid_q;
  assign disp.disp_pc_o     = pc_q;

endmodule
